// File: rtl/mem_req_arbiter.sv
// N-to-1 arbiter for the simplified DRAM request interface: registered request stage,
// round-robin or fixed-priority grant, and an in-order read-tag FIFO routing responses back.
module mem_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned TAG_DEPTH  = 16,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_is_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    resp_valid,
  output logic [DATA_WIDTH-1:0]                 resp_data,
  input  logic [NUM_REQ-1:0]                    resp_ready,
  output logic                                  mem_req_valid,
  output logic                                  mem_req_is_write,
  output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
  output logic [DATA_WIDTH-1:0]                 mem_req_data,
  input  logic                                  mem_req_ready,
  input  logic                                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_resp_data,
  output logic                                  mem_resp_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0]        outstanding,
  output logic                                  err_unexpected_resp
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW = $clog2(TAG_DEPTH);
  localparam int unsigned CW = $clog2(TAG_DEPTH + 1);
  localparam logic [CW-1:0] TAG_FULL = CW'(TAG_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  logic [IW-1:0]      rr_ptr;
  logic [CW-1:0]      wr_ptr, rd_ptr, count;
  logic [IW-1:0]      tag_mem [TAG_DEPTH];
  logic [IW-1:0]      head;
  logic               tag_empty;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_any;
  logic [IW-1:0]      grant_idx;
  logic               oreg_free, accept, push, pop;

  assign count       = wr_ptr - rd_ptr;
  assign tag_empty   = (count == '0);
  assign head        = tag_mem[rd_ptr[PW-1:0]];
  assign outstanding = count;

  // Reservation uses the count at cycle start; a same-cycle pop does not free a slot.
  assign eligible = req_valid & (req_is_write | {NUM_REQ{count != TAG_FULL}});

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ARB_MODE == 0) idx = (32'(rr_ptr) + k) % NUM_REQ;
      else               idx = k;
      if (!grant_any && eligible[IW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  // Held low while in reset so req_ready reads 0 regardless of requester activity.
  assign oreg_free = rst && (!mem_req_valid || mem_req_ready);
  assign accept    = grant_any && oreg_free;
  assign push      = accept && !req_is_write[grant_idx];
  assign pop       = mem_resp_valid && !tag_empty && resp_ready[head];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (mem_resp_valid && !tag_empty) resp_valid[head] = 1'b1;
  end

  assign resp_data      = mem_resp_data;
  assign mem_resp_ready = tag_empty || resp_ready[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_valid    <= 1'b0;
      mem_req_is_write <= 1'b0;
      mem_req_addr     <= '0;
      mem_req_data     <= '0;
      rr_ptr           <= '0;
    end else if (accept) begin
      mem_req_valid    <= 1'b1;
      mem_req_is_write <= req_is_write[grant_idx];
      mem_req_addr     <= req_addr[grant_idx];
      mem_req_data     <= req_data[grant_idx];
      rr_ptr           <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end else if (mem_req_ready) begin
      mem_req_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (mem_resp_valid && tag_empty) err_unexpected_resp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr[PW-1:0]] <= grant_idx;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: reset checks, a hand-computed vector table, directed corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int TD = 16;
  localparam int OW = 5;

  logic                   clk, rst;
  logic [N-1:0]           req_valid, req_is_write, resp_ready;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_data;
  logic                   mem_req_ready, mem_resp_valid;
  logic [DW-1:0]          mem_resp_data;

  logic [N-1:0]  req_ready, resp_valid;
  logic [DW-1:0] resp_data;
  logic          mem_req_valid, mem_req_is_write, mem_resp_ready, err_unexpected_resp;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [OW-1:0] outstanding;

  logic [N-1:0]  f_req_ready, f_resp_valid;
  logic [DW-1:0] f_resp_data, f_mem_req_data;
  logic          f_mem_req_valid, f_mem_req_is_write, f_mem_resp_ready, f_err;
  logic [AW-1:0] f_mem_req_addr;
  logic [OW-1:0] f_outstanding;

  mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_is_write(mem_req_is_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_ready(mem_resp_ready), .outstanding(outstanding),
    .err_unexpected_resp(err_unexpected_resp));

  mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD), .ARB_MODE(1)) dut_fixed (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_data(req_data), .req_ready(f_req_ready),
    .resp_valid(f_resp_valid), .resp_data(f_resp_data), .resp_ready(resp_ready),
    .mem_req_valid(f_mem_req_valid), .mem_req_is_write(f_mem_req_is_write),
    .mem_req_addr(f_mem_req_addr), .mem_req_data(f_mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_ready(f_mem_resp_ready), .outstanding(f_outstanding),
    .err_unexpected_resp(f_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: in-flight reads as a queue of client ids, plus the staged request.
  int            mq[$];
  bit            m_ov, m_ow, m_err;
  logic [AW-1:0] m_oa;
  logic [DW-1:0] m_od;
  int            m_rr;

  typedef struct {
    logic [N-1:0] v, w;
    logic         mrdy, rspv;
    logic [N-1:0] rrdy;
    logic [N-1:0] e_rdy, e_rv;
    logic         e_mrr;
    int           e_out;
    logic         e_mv;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_ow = 0; m_err = 0; m_oa = '0; m_od = '0; m_rr = 0;
  endtask

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (req_valid[idx] && (req_is_write[idx] || mq.size() < TD)) return idx;
    end
    return -1;
  endfunction

  task automatic set_idle();
    req_valid = '0; req_is_write = '0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; resp_ready = '1;
  endtask

  // Called at the falling edge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    int g, head;
    bit free, acc, pop;
    logic [N-1:0] er, ev;
    logic emr;
    #1;
    g = m_grant();
    free = !m_ov || mem_req_ready;
    acc = (g >= 0) && free;
    er = '0; ev = '0; emr = 1'b1; pop = 0;
    if (acc) er[g] = 1'b1;
    if (mq.size() > 0) begin
      head = mq[0];
      emr = resp_ready[head];
      if (mem_resp_valid) ev[head] = 1'b1;
      pop = mem_resp_valid && resp_ready[head];
    end
    chk("req_ready", req_ready, er);
    chk("resp_valid", resp_valid, ev);
    chk("mem_resp_ready", mem_resp_ready, emr);
    chk("resp_data", resp_data, mem_resp_data);
    chk("mem_req_valid", mem_req_valid, m_ov);
    chk("mem_req_is_write", mem_req_is_write, m_ow);
    chk("mem_req_addr", mem_req_addr, m_oa);
    chk("mem_req_data", mem_req_data, m_od);
    chk("outstanding", outstanding, mq.size());
    chk("err_unexpected_resp", err_unexpected_resp, m_err);
    @(posedge clk);
    if (mem_resp_valid && mq.size() == 0) m_err = 1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      m_ov = 1; m_ow = req_is_write[g]; m_oa = req_addr[g]; m_od = req_data[g];
      if (!req_is_write[g]) mq.push_back(g);
      m_rr = (g + 1) % N;
    end else if (mem_req_ready) begin
      m_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_is_write", mem_req_is_write, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_data", mem_req_data, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 1);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexpected_resp, 0);
    rst = 1'b1;
  endtask

  task automatic drain();
    set_idle();
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step();
    chk("drain_empty", outstanding, 0);
    set_idle();
    step();
  endtask

  initial begin
    logic [AW-1:0] held_addr;
    rst = 1'b0;
    set_idle();
    for (int i = 0; i < N; i++) begin
      req_addr[i] = (i == 2) ? 64'h40 : 64'h100 * (i + 1);
      req_data[i] = {16{32'hD000_0000 + i}};
    end
    mem_resp_data = {64{8'hAB}};

    //          v        w        mrdy rspv rrdy     e_rdy    e_rv     mrr out mv
    tbl[0]  = '{4'b0100, 4'b0000, 1, 0, 4'b1111, 4'b0100, 4'b0000, 1, 0, 0};
    tbl[1]  = '{4'b0000, 4'b0000, 1, 1, 4'b1111, 4'b0000, 4'b0100, 1, 1, 1};
    tbl[2]  = '{4'b0000, 4'b0000, 1, 0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0};
    tbl[3]  = '{4'b1111, 4'b0000, 1, 0, 4'b1111, 4'b1000, 4'b0000, 1, 0, 0};
    tbl[4]  = '{4'b1111, 4'b0000, 1, 0, 4'b1111, 4'b0001, 4'b0000, 1, 1, 1};
    tbl[5]  = '{4'b1111, 4'b0000, 0, 0, 4'b1111, 4'b0000, 4'b0000, 1, 2, 1};
    tbl[6]  = '{4'b0001, 4'b0000, 1, 1, 4'b1111, 4'b0001, 4'b1000, 1, 2, 1};
    tbl[7]  = '{4'b0000, 4'b0000, 1, 1, 4'b1110, 4'b0000, 4'b0001, 0, 2, 1};
    tbl[8]  = '{4'b0000, 4'b0000, 1, 1, 4'b1111, 4'b0000, 4'b0001, 1, 2, 0};
    tbl[9]  = '{4'b0000, 4'b0000, 1, 1, 4'b1111, 4'b0000, 4'b0001, 1, 1, 0};
    tbl[10] = '{4'b0010, 4'b0010, 1, 0, 4'b1111, 4'b0010, 4'b0000, 1, 0, 0};
    tbl[11] = '{4'b0000, 4'b0000, 1, 0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1};

    do_reset();
    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_is_write = tbl[i].w; mem_req_ready = tbl[i].mrdy;
      mem_resp_valid = tbl[i].rspv; resp_ready = tbl[i].rrdy;
      #1;
      chk($sformatf("vec%0d_req_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_resp_valid", i), resp_valid, tbl[i].e_rv);
      chk($sformatf("vec%0d_mem_resp_ready", i), mem_resp_ready, tbl[i].e_mrr);
      chk($sformatf("vec%0d_outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("vec%0d_mem_req_valid", i), mem_req_valid, tbl[i].e_mv);
      if (i == 1) chk("single_read_addr", mem_req_addr, 64'h40);
      if (i == 11) chk("write_staged", mem_req_is_write, 1);
      step();
    end

    // Fairness: continuous reads from every client.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = '1; req_is_write = '0;
      #1;
      chk("rr_order", req_ready, 4'b0001 << (c % 4));
      chk("fixed_prio", f_req_ready, 4'b0001);
      step();
    end
    drain();

    // Tag FIFO full: reads blocked, writes bypass, pop frees a slot only next cycle.
    for (int c = 0; c < TD; c++) begin
      req_valid = 4'b0001; req_is_write = '0;
      step();
    end
    req_valid = 4'b0001;
    #1;
    chk("tag_full_outstanding", outstanding, TD);
    chk("tag_full_read_blocked", req_ready, 0);
    step();
    req_valid = 4'b0011; req_is_write = 4'b0010;
    #1; chk("tag_full_write_bypass", req_ready, 4'b0010);
    step();
    req_valid = 4'b0001; req_is_write = '0; mem_resp_valid = 1'b1;
    #1; chk("tag_full_same_cycle_pop", req_ready, 0);
    step();
    mem_resp_valid = 1'b0;
    #1; chk("tag_full_read_after_pop", req_ready, 4'b0001);
    step();
    drain();

    // Response ordering and stall on resp_ready.
    for (int c = 0; c < 3; c++) begin
      req_valid = (c == 1) ? 4'b0001 : 4'b1000; req_is_write = '0;
      step();
    end
    set_idle();
    mem_resp_valid = 1'b1;
    #1; chk("order_first", resp_valid, 4'b1000);
    step();
    resp_ready = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("order_stall_valid", resp_valid, 4'b0001);
      chk("order_stall_ready", mem_resp_ready, 0);
      step();
    end
    resp_ready = '1;
    #1; chk("order_second", resp_valid, 4'b0001);
    step();
    #1; chk("order_third", resp_valid, 4'b1000);
    step();
    set_idle();
    step();

    // Backpressure: staged request must hold while mem_req_ready is low.
    req_valid = '1; req_is_write = 4'b0101;
    step();
    mem_req_ready = 1'b0;
    held_addr = mem_req_addr;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_no_ready", req_ready, 0);
      chk("bp_addr_stable", mem_req_addr, held_addr);
      step();
    end
    mem_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    drain();

    // Unexpected response sets a sticky flag.
    set_idle();
    mem_resp_valid = 1'b1;
    #1; chk("unexp_dropped_ready", mem_resp_ready, 1);
    step();
    set_idle();
    for (int c = 0; c < 3; c++) begin
      #1; chk("err_sticky", err_unexpected_resp, 1);
      step();
    end

    // Reset with reads in flight.
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0001; req_is_write = '0;
      step();
    end
    rst = 1'b0;
    #1;
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_mem_req_valid", mem_req_valid, 0);
    chk("midrst_err", err_unexpected_resp, 0);
    chk("midrst_req_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    mem_resp_valid = 1'b1;
    step();
    set_idle();
    step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      req_valid      = 4'($urandom);
      req_is_write   = 4'($urandom & $urandom);
      resp_ready     = 4'($urandom | $urandom);
      mem_req_ready  = ($urandom % 4) != 0;
      mem_resp_valid = ($urandom % 3) == 0;
      mem_resp_data  = {16{$urandom}};
      for (int i = 0; i < N; i++) begin
        req_addr[i] = {$urandom, $urandom};
        req_data[i] = {16{$urandom}};
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
